// File: rtl/clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_ctrl_pkg
// Purpose  : Shared encodings for the clock-enable scheduler: operating mode
//            codes, FSM state enum, counter widths and the mode-to-state
//            mapping helpers used by clk_step_ctrl.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package clk_ctrl_pkg;

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam int TICK_CNT_W = 16;
    localparam int BURST_W    = 8;

    typedef enum logic [2:0] {
        S_HALT       = 3'd0,
        S_RUN        = 3'd1,
        S_STEP       = 3'd2,
        S_BURST_IDLE = 3'd3,
        S_BURST_ACT  = 3'd4
    } state_e;

    // State entered when the mode input selects a given mode.
    function automatic state_e mode_home(input logic [1:0] m);
        case (m)
            MODE_HALT: return S_HALT;
            MODE_RUN:  return S_RUN;
            MODE_STEP: return S_STEP;
            default:   return S_BURST_IDLE;
        endcase
    endfunction

    // True when state s already belongs to mode m (BURST owns two states).
    function automatic logic state_owned_by(input state_e s, input logic [1:0] m);
        if (m == MODE_BURST) begin
            return (s == S_BURST_IDLE) || (s == S_BURST_ACT);
        end
        return s == mode_home(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchronizer plus counter debouncer for a raw push
//            button, with a one-cycle pulse on the debounced rising edge.
// Ports    : clk, rst_n  - clock / async active-low reset
//            btn         - raw asynchronous button, active-high
//            level       - debounced button level
//            rise        - one-cycle pulse when level goes 0 -> 1
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [DEB_W-1:0] deb_cnt;

    // deb_cnt holds the number of earlier consecutive disagreeing cycles, so
    // the level flips on the DEB_CYCLES-th disagreeing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_cnt <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                level   <= sync2;
                rise    <= sync2;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_step_ctrl
// Purpose  : Clock-enable scheduler for the mini core. Issues single-cycle
//            cpu_ce pulses in HALT / RUN / STEP / BURST modes.
// Ports    : CLK, RST_N  - clock / async active-low reset
//            mode        - 00 HALT, 01 RUN, 10 STEP, 11 BURST
//            div_period  - RUN/BURST tick period minus one
//            step_btn    - raw push button
//            burst_len   - pulses per burst (latched at burst start)
//            tick_clr    - synchronous clear of tick_count
//            cpu_ce      - registered one-cycle enable to the core
//            tick_count  - wrapping count of cpu_ce pulses
//            busy        - burst in progress
//            state_o     - current FSM state for debug LEDs
// Revision : 1.0 - initial release
// ============================================================================
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W      = 28,
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [1:0]            mode,
    input  logic [DIV_W-1:0]      div_period,
    input  logic                  step_btn,
    input  logic [BURST_W-1:0]    burst_len,
    input  logic                  tick_clr,
    output logic                  cpu_ce,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic                  busy,
    output logic [2:0]            state_o
);

    state_e             state, state_nxt;
    logic [DIV_W-1:0]   prescaler, presc_nxt;
    logic [BURST_W-1:0] remaining, rem_nxt;
    logic               busy_nxt;
    logic               ce_nxt;
    logic               tick;
    logic               btn_level;
    logic               btn_rise;
    logic               step_req;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_btn_debounce (
        .clk   (CLK),
        .rst_n (RST_N),
        .btn   (step_btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

    // rise is only ever asserted together with the new high level.
    assign step_req = btn_rise & btn_level;

    // ">=" rather than "==" so that lowering div_period below the current
    // count fires immediately instead of wrapping the prescaler.
    assign tick = (prescaler >= div_period);

    always_comb begin
        state_nxt = state;
        presc_nxt = '0;
        rem_nxt   = remaining;
        busy_nxt  = busy;
        ce_nxt    = 1'b0;

        if (!state_owned_by(state, mode)) begin
            // Mode change: jump to the new mode's state, abort any burst.
            state_nxt = mode_home(mode);
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    ce_nxt    = tick;
                    presc_nxt = tick ? '0 : prescaler + 1'b1;
                end
                S_STEP: begin
                    ce_nxt = step_req;
                end
                S_BURST_IDLE: begin
                    if (step_req && (burst_len != '0)) begin
                        rem_nxt   = burst_len;
                        busy_nxt  = 1'b1;
                        state_nxt = S_BURST_ACT;
                    end
                end
                S_BURST_ACT: begin
                    ce_nxt    = tick;
                    presc_nxt = tick ? '0 : prescaler + 1'b1;
                    if (tick) begin
                        rem_nxt = remaining - 1'b1;
                        if (remaining == BURST_W'(1)) begin
                            state_nxt = S_BURST_IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_HALT;
            prescaler <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            cpu_ce    <= 1'b0;
        end else begin
            state     <= state_nxt;
            prescaler <= presc_nxt;
            remaining <= rem_nxt;
            busy      <= busy_nxt;
            cpu_ce    <= ce_nxt;
        end
    end

    // Clear wins over a simultaneous pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_count <= '0;
        end else if (tick_clr) begin
            tick_count <= '0;
        end else if (cpu_ce) begin
            tick_count <= tick_count + 1'b1;
        end
    end

    assign state_o = state;

endmodule
`default_nettype wire

// File: doc/clk_step_ctrl.md
Name: clk_step_ctrl

Overview:
Clock-enable scheduler for the mini processor core. It replaces free-running divided clocks with a single-cycle enable pulse, cpu_ce, synchronous to CLK. It supports four modes: halt, continuous run at a programmable rate, single-step from a push button, and N-step burst. It sits between the board clock/button inputs and every clock-enabled register in the core.

Parameters:
DIV_W, 28, width of prescaler counter and div_period
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change
DEB_W, 20, width of debounce counter (must hold DEB_CYCLES)

Ports:
CLK  in  1  system clock, single clock domain
RST_N  in  1  asynchronous active-low reset
mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST; sampled every cycle
div_period  in  DIV_W  RUN/BURST tick period minus one
step_btn  in  1  raw asynchronous push button, active-high
burst_len  in  8  pulses per burst, latched at burst start
tick_clr  in  1  synchronous clear of tick_count
cpu_ce  out  1  one-cycle enable pulse to the core
tick_count  out  16  number of cpu_ce pulses issued, wraps
busy  out  1  high while a burst is in progress
state_o  out  3  current FSM state, for debug LEDs

Behaviour:
- Reset (async assert, sync release via RST_N): cpu_ce=0, tick_count=0, busy=0, prescaler=0, debounce counter=0, debounced level=0, state=S_HALT.
- Button path: 2-flop synchronizer, then debouncer. The debounced level takes the synchronized value after DEB_CYCLES consecutive cycles of disagreement. Any agreement resets the debounce counter. step_req is a 1-cycle pulse on the debounced rising edge only.
- Prescaler: counts only in S_RUN and S_BURST_ACT; held at 0 in all other states.
  - When prescaler >= div_period, the tick fires and the prescaler returns to 0. Otherwise it increments.
  - div_period=0 gives cpu_ce every cycle.
  - Lowering div_period below the current count fires on the next cycle, with no wrap through 2^DIV_W.
- FSM states: S_HALT(0), S_RUN(1), S_STEP(2), S_BURST_IDLE(3), S_BURST_ACT(4).
  - A mode change moves next cycle to the state for the new mode. BURST maps to S_BURST_IDLE.
  - A mode change aborts any burst in progress: busy drops and the prescaler clears.
  - S_RUN: cpu_ce = tick.
  - S_STEP: cpu_ce asserts the cycle after step_req, exactly one pulse per press.
  - S_BURST_IDLE: on step_req with burst_len!=0, latch remaining=burst_len, busy=1, go to S_BURST_ACT. With burst_len==0, step_req is ignored.
  - S_BURST_ACT: each tick gives cpu_ce=1 and remaining-1. After the pulse taking remaining to 0, return to S_BURST_IDLE and drop busy the same cycle as that last pulse's register update. step_req during S_BURST_ACT is ignored.
  - S_HALT: cpu_ce=0; step_req is ignored.
- cpu_ce is registered and never high two cycles in a row unless in RUN/BURST with div_period=0.
- tick_count increments by 1 per cpu_ce pulse, modulo 2^16 (0xFFFF -> 0x0000). tick_clr has priority: tick_clr and cpu_ce in the same cycle give tick_count=0.
- Reset mid-burst: everything returns to reset values immediately; no further pulses.

Decomposition:
- Shared package clk_ctrl_pkg holds:
  - mode encodings MODE_HALT/RUN/STEP/BURST
  - state encodings S_HALT..S_BURST_ACT
  - TICK_CNT_W=16 and BURST_W=8
- One sub-module, btn_debounce: synchronizer, debounce counter, rising-edge pulse; parameters DEB_CYCLES and DEB_W; outputs level and rise. The top holds the prescaler, FSM and counters.

Test Plan:
- Bench parameter DEB_CYCLES=4. Reset with mode=RUN, div_period=3, then release -> first cpu_ce 4 cycles after the FSM enters S_RUN; pulses every 4 cycles; tick_count=5 after 5 pulses.
- mode=STEP; press held 10 cycles with 2-cycle bounce at the start -> exactly one cpu_ce; tick_count increments by 1. A 3-cycle glitch press -> no pulse.
- mode=BURST, burst_len=5, div_period=1, one press -> 5 pulses 2 cycles apart; busy high from the cycle after step_req until the last pulse; a second press mid-burst is ignored, so the total is still 5.
- BURST with burst_len=0 and a press -> no pulses, busy stays 0. Then switch mode mid-burst (burst_len=8, after 3 pulses) to HALT -> no further pulses, busy=0, state_o=0.
- div_period=0xFFFF000 with the prescaler at 100, then change div_period to 10 -> cpu_ce the next cycle, then every 11 cycles.
- tick_count preset to 0xFFFF via 65535 RUN pulses at div_period=0 -> next pulse gives 0x0000. Assert tick_clr on the same cycle as a pulse -> tick_count=0. Assert RST_N low mid-RUN -> cpu_ce=0 and tick_count=0 immediately (async).
